cmd_pad_sequencer: RTL
======================

// Module: cmd_pad_sequencer
// PURPOSE
//  Sequences the single-bit SD CMD-line pad: serializes a 48-bit command frame through the pad,
//  turns the line around, hunts for the response start bit under a timeout and deserializes the
//  response. Sits between the command-control FSM (host side) and the CMD pad instance.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max sd_clock cycles in WAIT_RESP before timeout_err (>=1)
//  TURN_CYCLES     2   cycles in TURN after the end bit, line released, samples ignored (>=1)
// PORTS
//  sd_clock      in   1    SD card clock; all logic on posedge
//  reset         in   1    synchronous, active-high
//  cmd_start     in   1    1-cycle strobe: launch command; ignored unless state==IDLE
//  cmd_index     in   6    command index, captured on accepted cmd_start
//  cmd_arg       in   32   command argument, captured on accepted cmd_start
//  cmd_crc_in    in   7    CRC7 field used only when CMD_CRC7_EN is undefined
//  resp_type     in   2    0=no resp, 1=48-bit, 2=136-bit, 3=treated as 1; captured on start
//  pad_dir       out  1    to pad output_input: 1=drive, 0=receive
//  pad_enable    out  1    to pad enable
//  pad_data_in   out  1    to pad data_in (bit to transmit)
//  pad_data_out  in   1    from pad data_out (received bit, 1-cycle pad latency)
//  busy          out  1    1 whenever state!=IDLE
//  done          out  1    1-cycle pulse at end of every accepted command
//  timeout_err   out  1    valid with done; 1 = no start bit seen
//  crc_err       out  1    valid with done; 1 = 48-bit response CRC7 mismatch
//  resp_data     out  136  received bits, first bit (start bit) in MSB of used span, LSB-aligned
// BEHAVIOUR
//  - Reset: state=IDLE; pad_dir=0, pad_enable=0, pad_data_in=1; busy=0, done=0, timeout_err=0,
//    crc_err=0, resp_data=0; all counters 0. Reset mid-operation aborts at once, no done pulse.
//  - States: IDLE -> SEND -> (resp_type==0 ? DONE : TURN -> WAIT_RESP -> RECV -> DONE) -> IDLE.
//  - IDLE: pad_enable=0. Accepted cmd_start latches frame {1'b0,1'b1,cmd_index,cmd_arg,crc7,1'b1}
//    (48 bits, MSB first) and enters SEND next cycle.
//  - SEND: pad_enable=1, pad_dir=1, pad_data_in=frame[47-bit_cnt]; exactly 48 cycles, bit_cnt
//    6-bit 0..47. Line (o_port) lags pad_data_in by 1 cycle due to pad register.
//  - TURN: pad_enable=1, pad_dir=0 (line released) for TURN_CYCLES; pad_data_out ignored.
//  - WAIT_RESP: pad_enable=1, pad_dir=0. pad_data_out==0 (start bit) -> store it, go RECV with
//    rx_cnt=1. Else tmo_cnt++; when tmo_cnt reaches TIMEOUT_CYCLES with no start bit -> DONE with
//    timeout_err=1. Start bit seen in the same cycle as limit wins (no timeout).
//  - RECV: shift pad_data_out into resp_data LSB each cycle until rx_cnt==48 (type 1/3) or 136
//    (type 2) bits incl. start bit; then DONE. X/Z on pad_data_out is not filtered.
//  - DONE: one cycle; done=1, busy=1; then IDLE (busy=0). timeout_err/crc_err hold until next
//    accepted cmd_start, which clears them and resp_data.
//  - cmd_start asserted in DONE or any busy state: ignored, no queueing.
//  - Cycle count, resp_type 0: cmd_start@T -> SEND T+1..T+48 -> done@T+49.
// CONFIGURATION
//  CMD_CRC7_EN defined: CRC7 (x^7+x^3+1, init 0) computed over frame bits 47..8 and inserted;
//    cmd_crc_in ignored. For 48-bit responses CRC7 over resp bits 47..8 compared with bits 7..1;
//    mismatch -> crc_err=1. 136-bit responses never flag crc_err.
//  CMD_CRC7_EN undefined: frame CRC field = cmd_crc_in; no response check; crc_err tied 0.
// TESTING
//  1 reset mid-SEND (bit 20) -> next cycle IDLE, pad_enable=0, busy=0, no done pulse.
//  2 CMD0 arg=0, resp_type=0, CRC7_EN -> serial 0x40_00000000_95, done 49 cycles after start.
//  3 CMD8 arg=0x1AA, resp_type=1, model returns 48-bit 0x08_000001AA_13 after 5-cycle gap
//    -> resp_data[47:0]=0x08000001AA13, crc_err=0, timeout_err=0.
//  4 same with one flipped resp bit -> crc_err=1 (CRC7_EN); crc_err=0 with macro undefined.
//  5 resp_type=1, line held 1 -> done with timeout_err=1 exactly TIMEOUT_CYCLES after WAIT entry.
//  6 resp_type=2, 136-bit pattern -> resp_data equals pattern; cmd_start during busy ignored.

Source files
------------

// File: rtl/cmd_pad_sequencer_if.sv
// Host-side command/response bundle between the command-control FSM and cmd_pad_sequencer.
interface cmd_pad_sequencer_if;
    logic         cmd_start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [6:0]   cmd_crc_in;
    logic [1:0]   resp_type;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic         crc_err;
    logic [135:0] resp_data;

    modport master (
        output cmd_start, cmd_index, cmd_arg, cmd_crc_in, resp_type,
        input  busy, done, timeout_err, crc_err, resp_data
    );
    modport slave (
        input  cmd_start, cmd_index, cmd_arg, cmd_crc_in, resp_type,
        output busy, done, timeout_err, crc_err, resp_data
    );
endinterface

// File: rtl/cmd_pad_sequencer.sv
// SD CMD-line pad sequencer: serializes a 48-bit command, turns the line, hunts the response
// start bit under a timeout and deserializes it. Optional CRC7 generate/check under CMD_CRC7_EN.
module cmd_pad_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TURN_CYCLES    = 2
) (
    input  logic               sd_clock,
    input  logic               reset,
    cmd_pad_sequencer_if.slave host,
    output logic               pad_dir,
    output logic               pad_enable,
    output logic               pad_data_in,
    input  logic               pad_data_out
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_DONE} state_t;

    localparam logic [15:0] TURN_LAST = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t       state, state_nxt;
    logic [47:0]  frame;
    logic [5:0]   bit_cnt;
    logic [15:0]  turn_cnt;
    logic [15:0]  tmo_cnt;
    logic [7:0]   rx_cnt;
    logic [1:0]   rtype_q;
    logic [135:0] resp_q;
    logic         tmo_q;
    logic [7:0]   rx_last;
    logic [135:0] resp_shift;
    logic [6:0]   crc_field;

    // Index of the final response bit: 136-bit for type 2, 48-bit otherwise (type 3 aliases 1).
    assign rx_last    = (rtype_q == 2'd2) ? 8'd135 : 8'd47;
    assign resp_shift = {resp_q[134:0], pad_data_out};

`ifdef CMD_CRC7_EN
    logic crc_q;
    logic crc_bad;

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc_field = crc7_40({2'b01, host.cmd_index, host.cmd_arg});
    // Checked on the final shift so the completed 48-bit frame is visible in resp_shift.
    assign crc_bad   = (rtype_q != 2'd2) &&
                       (crc7_40(resp_shift[47:8]) != resp_shift[7:1]);
    assign host.crc_err = crc_q;
`else
    assign crc_field    = host.cmd_crc_in;
    assign host.crc_err = 1'b0;
`endif

    always_ff @(posedge sd_clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (host.cmd_start) state_nxt = S_SEND;
            S_SEND: if (bit_cnt == 6'd47) state_nxt = (rtype_q == 2'd0) ? S_DONE : S_TURN;
            S_TURN: if (turn_cnt == TURN_LAST) state_nxt = S_WAIT;
            // A start bit on the limit cycle takes priority over the timeout.
            S_WAIT: begin
                if (pad_data_out == 1'b0)     state_nxt = S_RECV;
                else if (tmo_cnt == TMO_LAST) state_nxt = S_DONE;
            end
            S_RECV: if (rx_cnt == rx_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pad_enable  = 1'b0;
        pad_dir     = 1'b0;
        pad_data_in = 1'b1;
        case (state)
            S_SEND: begin
                pad_enable  = 1'b1;
                pad_dir     = 1'b1;
                pad_data_in = frame[47];
            end
            S_TURN, S_WAIT, S_RECV: pad_enable = 1'b1;
            default: ;
        endcase
    end

    assign host.busy        = (state != S_IDLE);
    assign host.done        = (state == S_DONE);
    assign host.timeout_err = tmo_q;
    assign host.resp_data   = resp_q;

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            frame    <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            tmo_cnt  <= '0;
            rx_cnt   <= '0;
            rtype_q  <= '0;
            resp_q   <= '0;
            tmo_q    <= 1'b0;
`ifdef CMD_CRC7_EN
            crc_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (host.cmd_start) begin
                    frame    <= {2'b01, host.cmd_index, host.cmd_arg, crc_field, 1'b1};
                    rtype_q  <= host.resp_type;
                    bit_cnt  <= '0;
                    turn_cnt <= '0;
                    tmo_cnt  <= '0;
                    rx_cnt   <= '0;
                    resp_q   <= '0;
                    tmo_q    <= 1'b0;
`ifdef CMD_CRC7_EN
                    crc_q    <= 1'b0;
`endif
                end
                S_SEND: begin
                    frame   <= {frame[46:0], 1'b1};
                    bit_cnt <= (bit_cnt == 6'd47) ? 6'd0 : bit_cnt + 6'd1;
                end
                S_TURN: turn_cnt <= turn_cnt + 16'd1;
                S_WAIT: begin
                    if (pad_data_out == 1'b0) begin
                        resp_q <= resp_shift;
                        rx_cnt <= 8'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (tmo_cnt == TMO_LAST) tmo_q <= 1'b1;
                    end
                end
                S_RECV: begin
                    resp_q <= resp_shift;
                    rx_cnt <= rx_cnt + 8'd1;
`ifdef CMD_CRC7_EN
                    if (rx_cnt == rx_last) crc_q <= crc_bad;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
